// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH, EXEC, optional MEM, UPDATE.
// Owns the program counter and handshakes with instruction/data memory.
module pc_sequencer #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          PC_STEP  = 4,
   parameter int          TIMEOUT  = 16
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        halt_instr,
   input  logic        mem_op,
   input  logic        branch_taken,
   input  logic [31:0] branch_offset,
   input  logic        jump,
   input  logic [31:0] jump_target,
   input  logic        jump_reg,
   input  logic [31:0] reg_target,
   output logic [31:0] pc,
   output logic [31:0] pc_next,
   output logic        pc_write,
   output logic        imem_req,
   output logic        dmem_req,
   output logic        exec_en,
   output logic [2:0]  state,
   output logic        halted,
   output logic        fault
);

   localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_UPDATE = 3'd4,
      S_HALT   = 3'd5,
      S_FAULT  = 3'd6
   } state_t;

   state_t          r_state;
   logic [31:0]     r_pc;
   logic [CW-1:0]   r_cnt;
   logic            r_pc_write;
   logic            r_imem_req;
   logic            r_dmem_req;
   logic            r_exec_en;
   logic            r_halted;
   logic            r_fault;
   logic            r_jr;
   logic            r_j;
   logic            r_bt;
   logic [31:0]     r_off;
   logic [31:0]     r_jt;
   logic [31:0]     r_rt;
   logic [31:0]     w_pc_next;
   logic [31:0]     w_exec_next;

   function automatic logic [31:0] f_sel(
      input logic        jr,
      input logic        j,
      input logic        bt,
      input logic [31:0] off,
      input logic [31:0] jt,
      input logic [31:0] rt,
      input logic [31:0] cur
   );
      if (jr)      return rt;
      else if (j)  return jt;
      else if (bt) return cur + off;
      else         return cur + 32'(PC_STEP);
   endfunction

   assign w_pc_next   = f_sel(r_jr, r_j, r_bt, r_off, r_jt, r_rt, r_pc);
   // Same selection on live decode, so pc_write can be registered on UPDATE entry
   assign w_exec_next = f_sel(jump_reg, jump, branch_taken, branch_offset,
                              jump_target, reg_target, r_pc);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_pc       <= RESET_PC;
         r_cnt      <= '0;
         r_pc_write <= 1'b0;
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_exec_en  <= 1'b0;
         r_halted   <= 1'b0;
         r_fault    <= 1'b0;
         r_jr       <= 1'b0;
         r_j        <= 1'b0;
         r_bt       <= 1'b0;
         r_off      <= '0;
         r_jt       <= '0;
         r_rt       <= '0;
      end else begin
         r_pc_write <= 1'b0;
         r_imem_req <= 1'b0;
         r_dmem_req <= 1'b0;
         r_exec_en  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                  r_cnt      <= '0;
               end
            end
            S_FETCH: begin
               if (imem_ready) begin
                  r_state   <= S_EXEC;
                  r_exec_en <= 1'b1;
                  r_cnt     <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_cnt      <= r_cnt + CW'(1);
                  r_imem_req <= 1'b1;
               end
            end
            S_EXEC: begin
               r_jr  <= jump_reg;
               r_j   <= jump;
               r_bt  <= branch_taken;
               r_off <= branch_offset;
               r_jt  <= jump_target;
               r_rt  <= reg_target;
               r_cnt <= '0;
               if (halt_instr) begin
                  r_state  <= S_HALT;
                  r_halted <= 1'b1;
               end else if (mem_op) begin
                  r_state    <= S_MEM;
                  r_dmem_req <= 1'b1;
               end else begin
                  r_state    <= S_UPDATE;
                  r_pc_write <= (w_exec_next[1:0] == 2'b00);
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_state    <= S_UPDATE;
                  r_pc_write <= (w_pc_next[1:0] == 2'b00);
                  r_cnt      <= '0;
               end else if (r_cnt == CNT_LAST) begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_cnt      <= r_cnt + CW'(1);
                  r_dmem_req <= 1'b1;
               end
            end
            S_UPDATE: begin
               if (w_pc_next[1:0] != 2'b00) begin
                  r_state <= S_FAULT;
                  r_fault <= 1'b1;
               end else begin
                  r_pc       <= w_pc_next;
                  r_state    <= S_FETCH;
                  r_imem_req <= 1'b1;
                  r_cnt      <= '0;
               end
            end
            S_HALT:  r_halted <= 1'b1;
            S_FAULT: r_fault  <= 1'b1;
            default: r_state  <= S_IDLE;
         endcase
      end
   end

   assign pc       = r_pc;
   assign pc_next  = w_pc_next;
   assign pc_write = r_pc_write;
   assign imem_req = r_imem_req;
   assign dmem_req = r_dmem_req;
   assign exec_en  = r_exec_en;
   assign state    = r_state;
   assign halted   = r_halted;
   assign fault    = r_fault;

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer against an instruction-level model.
// Each task drives one scenario and compares DUT results inline.
module tb_pc_sequencer;

   localparam int TO = 16;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        imem_ready;
   logic        dmem_ready;
   logic        halt_instr;
   logic        mem_op;
   logic        branch_taken;
   logic [31:0] branch_offset;
   logic        jump;
   logic [31:0] jump_target;
   logic        jump_reg;
   logic [31:0] reg_target;
   logic [31:0] pc;
   logic [31:0] pc_next;
   logic        pc_write;
   logic        imem_req;
   logic        dmem_req;
   logic        exec_en;
   logic [2:0]  state;
   logic        halted;
   logic        fault;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        jr, j, bt, mem, halt;
      logic [31:0] off, jt, rt;
      int          fd, md;
   } instr_t;

   string       obs_s;
   int          obs_pcw_n, obs_pcw_at, obs_dreq_n;
   logic [31:0] obs_pcnext;
   logic [31:0] m_pc;

   pc_sequencer #(.RESET_PC(32'h0), .PC_STEP(4), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset), .start(start),
      .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .halt_instr(halt_instr), .mem_op(mem_op),
      .branch_taken(branch_taken), .branch_offset(branch_offset),
      .jump(jump), .jump_target(jump_target),
      .jump_reg(jump_reg), .reg_target(reg_target),
      .pc(pc), .pc_next(pc_next), .pc_write(pc_write),
      .imem_req(imem_req), .dmem_req(dmem_req), .exec_en(exec_en),
      .state(state), .halted(halted), .fault(fault)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] model_next(instr_t in, logic [31:0] cur);
      if (in.jr) return in.rt;
      if (in.j)  return in.jt;
      if (in.bt) return cur + in.off;
      return cur + 32'd4;
   endfunction

   function automatic string exp_trace(instr_t in);
      string s = "";
      for (int i = 0; i <= in.fd; i++) s = {s, "1"};
      s = {s, "2"};
      if (!in.halt) begin
         if (in.mem) for (int i = 0; i <= in.md; i++) s = {s, "3"};
         s = {s, "4"};
      end
      return s;
   endfunction

   function automatic instr_t seq_instr();
      instr_t t;
      t.jr = 0; t.j = 0; t.bt = 0; t.mem = 0; t.halt = 0;
      t.off = 0; t.jt = 0; t.rt = 0; t.fd = 0; t.md = 0;
      return t;
   endfunction

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic quiet();
      start = 0; imem_ready = 0; dmem_ready = 0;
      halt_instr = 0; mem_op = 0; branch_taken = 0; jump = 0; jump_reg = 0;
      branch_offset = 0; jump_target = 0; reg_target = 0;
   endtask

   task automatic junk();
      start = 1'($urandom); imem_ready = 1'($urandom);
      dmem_ready = 1'($urandom); halt_instr = 1'($urandom);
      mem_op = 1'($urandom); branch_taken = 1'($urandom);
      jump = 1'($urandom); jump_reg = 1'($urandom);
      branch_offset = $urandom; jump_target = $urandom; reg_target = $urandom;
   endtask

   task automatic boot();
      quiet();
      reset = 0;
      tick(); tick();
      reset = 1;
      tick();
      start = 1;
      tick();
      start = 0;
      m_pc = 32'h0;
   endtask

   // Drives one instruction on the model's timeline and records what the DUT did
   task automatic run_instr(input instr_t in);
      int nf, nm, total;
      nf = in.fd + 1;
      nm = in.mem ? in.md + 1 : 0;
      total = nf + 1 + (in.halt ? 0 : nm + 1);
      obs_s = ""; obs_pcw_n = 0; obs_pcw_at = -1; obs_dreq_n = 0;
      obs_pcnext = 32'hDEAD_BEEF;
      for (int c = 0; c < total; c++) begin
         junk();
         if (c < nf) imem_ready = (c == nf - 1);
         else if (c == nf) begin
            halt_instr = in.halt; mem_op = in.mem;
            branch_taken = in.bt; branch_offset = in.off;
            jump = in.j; jump_target = in.jt;
            jump_reg = in.jr; reg_target = in.rt;
         end else if (c < nf + 1 + nm) dmem_ready = (c == nf + nm);
         else obs_pcnext = pc_next;
         obs_s = {obs_s, $sformatf("%0d", state)};
         if (pc_write) begin obs_pcw_n++; obs_pcw_at = c; end
         if (dmem_req) obs_dreq_n++;
         tick();
      end
      quiet();
   endtask

   task automatic test_reset();
      quiet();
      reset = 0;
      tick(); tick();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d exp 0", state); end
      checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h exp 0", pc); end
      checks++;
      if ({pc_write, imem_req, dmem_req, exec_en, halted, fault} !== 6'b0) begin
         errors++; $display("FAIL reset_outs: got %b exp 000000",
            {pc_write, imem_req, dmem_req, exec_en, halted, fault});
      end
      reset = 1;
      tick(); tick(); tick();
      checks++; if (state !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d exp 0", state); end
      start = 1;
      tick();
      start = 0;
      checks++; if (state !== 3'd1 || imem_req !== 1'b1) begin
         errors++; $display("FAIL start_fetch: got st=%0d req=%b exp st=1 req=1", state, imem_req);
      end
   endtask

   task automatic test_sequential();
      instr_t t;
      logic [31:0] e;
      boot();
      t = seq_instr();
      for (int k = 0; k < 3; k++) begin
         e = model_next(t, m_pc);
         run_instr(t);
         checks++; if (obs_s != "124") begin errors++; $display("FAIL seq_trace: got %s exp 124", obs_s); end
         checks++; if (obs_pcw_n != 1 || obs_pcw_at != 2) begin
            errors++; $display("FAIL seq_pcw: got n=%0d at=%0d exp n=1 at=2", obs_pcw_n, obs_pcw_at);
         end
         checks++; if (pc !== e) begin errors++; $display("FAIL seq_pc: got %h exp %h", pc, e); end
         m_pc = e;
      end
   endtask

   task automatic test_priority();
      instr_t t;
      logic [31:0] e;
      for (int v = 0; v < 3; v++) begin
         boot();
         run_instr(seq_instr()); run_instr(seq_instr());
         m_pc = 32'd8;
         t = seq_instr();
         t.bt = 1; t.off = 32'hFFFF_FFF8;
         t.j = (v < 2); t.jt = 32'h100;
         t.jr = (v < 1); t.rt = 32'h200;
         e = model_next(t, m_pc);
         run_instr(t);
         checks++; if (obs_pcnext !== e) begin errors++; $display("FAIL prio_pcnext%0d: got %h exp %h", v, obs_pcnext, e); end
         checks++; if (pc !== e) begin errors++; $display("FAIL prio_pc%0d: got %h exp %h", v, pc, e); end
      end
   endtask

   task automatic test_wrap();
      instr_t t;
      boot();
      t = seq_instr(); t.j = 1; t.jt = 32'hFFFF_FFFC;
      run_instr(t);
      checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_jump: got %h exp fffffffc", pc); end
      m_pc = 32'hFFFF_FFFC;
      t = seq_instr();
      run_instr(t);
      checks++; if (pc !== model_next(t, m_pc) || fault !== 1'b0 || state !== 3'd1) begin
         errors++; $display("FAIL wrap_seq: got pc=%h f=%b st=%0d exp pc=0 f=0 st=1", pc, fault, state);
      end
   endtask

   task automatic test_memory();
      instr_t t;
      int n;
      int mds[2] = '{5, TO - 1};
      foreach (mds[i]) begin
         boot();
         t = seq_instr(); t.mem = 1; t.md = mds[i];
         run_instr(t);
         checks++; if (obs_dreq_n != mds[i] + 1) begin
            errors++; $display("FAIL mem_dreq: got %0d exp %0d", obs_dreq_n, mds[i] + 1);
         end
         checks++; if (obs_s != exp_trace(t)) begin errors++; $display("FAIL mem_trace: got %s exp %s", obs_s, exp_trace(t)); end
         checks++; if (pc !== 32'd4) begin errors++; $display("FAIL mem_pc: got %h exp 4", pc); end
      end
      boot();
      imem_ready = 1; tick();
      imem_ready = 0; mem_op = 1; tick();
      quiet();
      n = 0;
      for (int c = 0; c < 4 * TO && state == 3'd3; c++) begin n++; tick(); end
      checks++; if (n != TO) begin errors++; $display("FAIL dmem_timeout_len: got %0d exp %0d", n, TO); end
      checks++; if (state !== 3'd6 || fault !== 1'b1 || pc !== 32'h0) begin
         errors++; $display("FAIL dmem_timeout: got st=%0d f=%b pc=%h exp st=6 f=1 pc=0", state, fault, pc);
      end
   endtask

   task automatic test_fetch_timeout();
      int n;
      boot();
      n = 0;
      for (int c = 0; c < 4 * TO && state == 3'd1; c++) begin n++; tick(); end
      checks++; if (n != TO) begin errors++; $display("FAIL imem_timeout_len: got %0d exp %0d", n, TO); end
      checks++; if (state !== 3'd6 || fault !== 1'b1 || pc !== 32'h0 || imem_req !== 1'b0) begin
         errors++; $display("FAIL imem_timeout: got st=%0d f=%b pc=%h req=%b exp 6 1 0 0", state, fault, pc, imem_req);
      end
      start = 1; tick(); tick(); tick(); start = 0;
      checks++; if (state !== 3'd6) begin errors++; $display("FAIL fault_sticky: got %0d exp 6", state); end
   endtask

   task automatic test_misalign();
      instr_t t;
      boot();
      run_instr(seq_instr());
      m_pc = 32'd4;
      t = seq_instr(); t.j = 1; t.jt = 32'h102;
      run_instr(t);
      checks++; if (obs_pcw_n != 0) begin errors++; $display("FAIL misalign_pcw: got %0d exp 0", obs_pcw_n); end
      checks++; if (state !== 3'd6 || fault !== 1'b1 || pc !== m_pc) begin
         errors++; $display("FAIL misalign: got st=%0d f=%b pc=%h exp 6 1 %h", state, fault, pc, m_pc);
      end
   endtask

   task automatic test_halt();
      instr_t t;
      boot();
      t = seq_instr(); t.halt = 1; t.mem = 1; t.bt = 1; t.off = 32'h40;
      run_instr(t);
      checks++; if (state !== 3'd5 || halted !== 1'b1 || pc !== 32'h0) begin
         errors++; $display("FAIL halt: got st=%0d h=%b pc=%h exp 5 1 0", state, halted, pc);
      end
      for (int k = 0; k < 4; k++) begin start = 1; tick(); start = 0; tick(); end
      checks++; if (state !== 3'd5 || halted !== 1'b1 || obs_pcw_n != 0) begin
         errors++; $display("FAIL halt_sticky: got st=%0d h=%b exp 5 1", state, halted);
      end
   endtask

   task automatic test_async_reset();
      boot();
      run_instr(seq_instr());
      imem_ready = 1; tick();
      imem_ready = 0; mem_op = 1; tick();
      quiet(); tick(); tick();
      checks++; if (state !== 3'd3 || pc !== 32'd4) begin
         errors++; $display("FAIL areset_pre: got st=%0d pc=%h exp 3 4", state, pc);
      end
      #2 reset = 0;
      #1;
      checks++;
      if (state !== 3'd0 || pc !== 32'h0 ||
          {pc_write, imem_req, dmem_req, exec_en, halted, fault} !== 6'b0) begin
         errors++; $display("FAIL areset: got st=%0d pc=%h outs=%b exp 0 0 000000", state, pc,
            {pc_write, imem_req, dmem_req, exec_en, halted, fault});
      end
      tick();
      reset = 1;
   endtask

   task automatic test_random();
      instr_t t;
      logic [31:0] e;
      logic [2:0]  est;
      boot();
      for (int k = 0; k < 60; k++) begin
         t.jr = ($urandom_range(0, 7) == 0);
         t.j = ($urandom_range(0, 7) == 0);
         t.bt = ($urandom_range(0, 3) == 0);
         t.mem = ($urandom_range(0, 2) == 0);
         t.halt = ($urandom_range(0, 15) == 0);
         t.off = 32'(($urandom_range(0, 127) - 64) * 4);
         t.jt = $urandom & 32'hFFFF_FFFC;
         t.rt = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) t.jt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 9) == 0) t.rt[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 19) == 0) t.off[1:0] = 2'($urandom_range(1, 3));
         t.fd = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
         t.md = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TO - 1) : $urandom_range(0, 2);
         e = model_next(t, m_pc);
         run_instr(t);
         est = t.halt ? 3'd5 : (e[1:0] != 2'b00) ? 3'd6 : 3'd1;
         checks++; if (obs_s != exp_trace(t)) begin errors++; $display("FAIL rnd_trace%0d: got %s exp %s", k, obs_s, exp_trace(t)); end
         checks++; if (state !== est) begin errors++; $display("FAIL rnd_state%0d: got %0d exp %0d", k, state, est); end
         checks++; if (obs_pcw_n != ((est == 3'd1) ? 1 : 0)) begin
            errors++; $display("FAIL rnd_pcw%0d: got %0d exp %0d", k, obs_pcw_n, (est == 3'd1) ? 1 : 0);
         end
         checks++; if (obs_dreq_n != ((t.mem && !t.halt) ? t.md + 1 : 0)) begin
            errors++; $display("FAIL rnd_dreq%0d: got %0d", k, obs_dreq_n);
         end
         if (!t.halt) begin
            checks++; if (obs_pcnext !== e) begin errors++; $display("FAIL rnd_pcnext%0d: got %h exp %h", k, obs_pcnext, e); end
         end
         if (est == 3'd1) m_pc = e;
         checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc%0d: got %h exp %h", k, pc, m_pc); end
         if (est != 3'd1) boot();
      end
   endtask

   initial begin
      quiet();
      reset = 1;
      test_reset();
      test_sequential();
      test_priority();
      test_wrap();
      test_memory();
      test_fetch_timeout();
      test_misalign();
      test_halt();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Multi-cycle instruction sequencer that owns the processor program counter and steps each instruction through FETCH, EXEC, optional MEM and UPDATE.
- Handshakes with instruction and data memory, with a per-wait timeout.
- Selects the next PC from sequential, branch, jump and jump-register sources.
- Sits between decode/branch logic and the memories.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 4, sequential increment in bytes.
- TIMEOUT, 16, maximum wait cycles for imem_ready/dmem_ready before FAULT; must be >= 2.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 resets immediately.
- start  in  1  leave IDLE.
- imem_ready  in  1  instruction fetch complete.
- dmem_ready  in  1  data access complete.
- halt_instr  in  1  decoded halt; sampled in EXEC.
- mem_op  in  1  decoded load/store; sampled in EXEC.
- branch_taken  in  1  sampled in EXEC.
- branch_offset  in  32  signed byte offset; sampled in EXEC.
- jump  in  1  sampled in EXEC.
- jump_target  in  32  absolute target; sampled in EXEC.
- jump_reg  in  1  sampled in EXEC.
- reg_target  in  32  register target; sampled in EXEC.
- pc  out  32  current PC (registered).
- pc_next  out  32  selected next PC; combinational from latched selection.
- pc_write  out  1  one-cycle pulse when pc updates.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data request.
- exec_en  out  1  one-cycle execute strobe.
- state  out  3  IDLE=0, FETCH=1, EXEC=2, MEM=3, UPDATE=4, HALT=5, FAULT=6.
- halted  out  1  high in HALT.
- fault  out  1  high in FAULT.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=RESET_PC.
  - pc_write, imem_req, dmem_req, exec_en, halted and fault all 0.
  - Wait counter and latched decode cleared.
  - Reset mid-instruction abandons that instruction with no pc update.
- Registered outputs are decoded from state: imem_req=(FETCH), exec_en=(EXEC), dmem_req=(MEM), pc_write=(UPDATE and target aligned), halted=(HALT), fault=(FAULT).
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH:
  - imem_ready=1 -> EXEC and counter cleared.
  - Otherwise the counter increments; counter==TIMEOUT-1 without ready -> FAULT.
- EXEC:
  - Latch halt_instr, mem_op, branch_taken, branch_offset, jump, jump_target, jump_reg, reg_target.
  - halt_instr -> HALT with pc unchanged; mem_op and branches are ignored.
  - Else mem_op -> MEM; else -> UPDATE.
- MEM: same ready/timeout rule as FETCH using dmem_ready; ready -> UPDATE.
- UPDATE:
  - pc_next priority: jump_reg -> reg_target; else jump -> jump_target; else branch_taken -> pc+branch_offset; else pc+PC_STEP.
  - All arithmetic is 32-bit modulo 2^32; wrap-around is silent.
  - pc_next[1:0]!=0 -> FAULT with pc unchanged and pc_write=0.
  - Otherwise pc<=pc_next, pc_write=1 for exactly this cycle, then -> FETCH.
- HALT and FAULT are terminal until reset; start is ignored there.
- Ready inputs outside their wait state are ignored; decode inputs outside EXEC are ignored.
- Latency with immediate ready: non-memory instruction takes 3 cycles (FETCH, EXEC, UPDATE); memory instruction takes 4.
- pc_next is valid only in UPDATE.

Test Plan:
- Sequential: release reset, start=1, imem_ready always 1, no decode flags -> pc 0->4->8, pc_write pulses every 3rd cycle, state cycles 1,2,4.
- Branch/jump priority: at pc=8 in EXEC, branch_taken=1, offset=-8, jump=1, target=0x100, jump_reg=1, reg_target=0x200 -> pc=0x200. Repeat with jump_reg=0 -> 0x100; jump=0 -> 0x0.
- Wrap: jump to 0xFFFF_FFFC, next sequential -> pc=0x0000_0000, no fault.
- Memory + timeout:
  - mem_op=1, dmem_ready after 5 cycles -> dmem_req high exactly 6 cycles, then UPDATE.
  - Separately, imem_ready held 0 -> FAULT after TIMEOUT cycles in FETCH, fault=1, pc unchanged.
- Misalign/halt:
  - jump_target=0x102 -> FAULT, pc_write never asserted.
  - halt_instr=1 -> HALT, halted=1, further start pulses ignored.
- Async reset: assert reset=0 mid-MEM between clock edges -> outputs cleared immediately, pc=RESET_PC, state=IDLE.
